// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - buffered ALU result stage with sticky flags
// Optional delivered-result counter enabled by macro ALU_RESULT_STATS_EN.
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      s,
    input  logic             eq,
    input  logic             cary,
    input  logic             of,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_s,
    output logic             out_eq,
    output logic             out_cary,
    output logic             out_of,
    output logic [2:0]       out_op,
    output logic             sticky_of,
    output logic             sticky_cary,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] pop_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // Entry layout: {s[37:6], eq[5], cary[4], of[3], op[2:0]}
    logic [37:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_sticky_of;
    logic          r_sticky_cary;

    logic          w_push;
    logic          w_pop;
    logic          w_arith;
    logic [37:0]   w_entry;
    logic [37:0]   w_head;

    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Logic-op slices leave carry/overflow undefined, so they are forced low.
    assign w_arith = (op == 3'b000) || (op == 3'b001);
    assign w_entry = {s, eq, cary & w_arith, of & w_arith, op};
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // A setting pop takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_of   <= 1'b0;
            r_sticky_cary <= 1'b0;
        end else begin
            if (w_pop && w_head[3]) begin
                r_sticky_of <= 1'b1;
            end else if (sticky_clr) begin
                r_sticky_of <= 1'b0;
            end
            if (w_pop && w_head[4]) begin
                r_sticky_cary <= 1'b1;
            end else if (sticky_clr) begin
                r_sticky_cary <= 1'b0;
            end
        end
    end

    assign sticky_of   = r_sticky_of;
    assign sticky_cary = r_sticky_cary;

    assign out_s    = out_valid ? w_head[37:6] : 32'd0;
    assign out_eq   = out_valid ? w_head[5]    : 1'b0;
    assign out_cary = out_valid ? w_head[4]    : 1'b0;
    assign out_of   = out_valid ? w_head[3]    : 1'b0;
    assign out_op   = out_valid ? w_head[2:0]  : 3'd0;

`ifdef ALU_RESULT_STATS_EN
    logic [CNT_W-1:0] r_pop_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pop_count <= '0;
        end else if (w_pop && (r_pop_count != '1)) begin
            r_pop_count <= r_pop_count + CNT_W'(1);
        end
    end

    assign pop_count = r_pop_count;
`else
    assign pop_count = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage
// Vector table, directed corner sequences and randomized traffic against a queue model.
module tb_alu_result_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      s;
    logic             eq, cary, of;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_s;
    logic             out_eq, out_cary, out_of;
    logic [2:0]       out_op;
    logic             sticky_of, sticky_cary;
    logic             sticky_clr;
    logic [CNT_W-1:0] pop_count;

    int checks = 0;
    int errors = 0;

    logic [37:0] mq[$];
    logic        m_sof;
    logic        m_scary;
    int          m_pops;

    alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .eq(eq), .cary(cary), .of(of), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_eq(out_eq), .out_cary(out_cary), .out_of(out_of), .out_op(out_op),
        .sticky_of(sticky_of), .sticky_cary(sticky_cary), .sticky_clr(sticky_clr),
        .pop_count(pop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] exp_pops();
`ifdef ALU_RESULT_STATS_EN
        if (m_pops > (1 << CNT_W) - 1) return '1;
        return CNT_W'(m_pops);
`else
        return '0;
`endif
    endfunction

    task automatic check_model(input string tag);
        logic [37:0] h;
        bit          v;
        v = (mq.size() != 0);
        h = v ? mq[0] : 38'd0;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() != DEPTH));
        chk({tag, ".out_fields"}, 64'({out_s, out_eq, out_cary, out_of, out_op}), 64'(h));
        chk({tag, ".sticky"}, 64'({sticky_of, sticky_cary}), 64'({m_sof, m_scary}));
        chk({tag, ".pop_count"}, 64'(pop_count), 64'(exp_pops()));
    endtask

    task automatic model_reset();
        mq.delete();
        m_sof   = 1'b0;
        m_scary = 1'b0;
        m_pops  = 0;
    endtask

    // One clock: model evaluates the pre-edge handshake, DUT is sampled 1ns after the edge.
    task automatic tick(input string tag);
        bit          do_push, do_pop;
        logic [37:0] head;
        logic        arith;
        do_push = in_valid && (mq.size() != DEPTH);
        do_pop  = out_ready && (mq.size() != 0);
        head    = (mq.size() != 0) ? mq[0] : 38'd0;
        arith   = (op == 3'd0) || (op == 3'd1);
        @(posedge clk);
        #1;
        if (do_pop) begin
            void'(mq.pop_front());
            m_pops++;
        end
        m_sof   = (do_pop && head[3]) ? 1'b1 : (sticky_clr ? 1'b0 : m_sof);
        m_scary = (do_pop && head[4]) ? 1'b1 : (sticky_clr ? 1'b0 : m_scary);
        if (do_push) mq.push_back({s, eq, cary & arith, of & arith, op});
        check_model(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 0; s = 0; eq = 0; cary = 0; of = 0; op = 0;
        out_ready = 0; sticky_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        model_reset();
        check_model("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_val(input logic [31:0] v, input logic [2:0] o, input logic rdy, input string tag);
        in_valid = 1; s = v; op = o; eq = 0; cary = 0; of = 0; out_ready = rdy;
        tick(tag);
        in_valid = 0;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] s;
        logic        eq, cary, of;
        logic [2:0]  op;
        logic        ordy, clr;
        logic        e_valid;
        logic [31:0] e_s;
        logic        e_eq, e_cary, e_of;
        logic        e_scary, e_sof, e_iready;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1, 32'hF0F0_0000, 0, 1, 0, 3'd0, 1, 0,  1, 32'hF0F0_0000, 0, 1, 0,  0, 0, 1};
        tbl[1] = '{0, 32'h0,         0, 0, 0, 3'd0, 1, 0,  0, 32'h0,         0, 0, 0,  1, 0, 1};
        tbl[2] = '{0, 32'h0,         0, 0, 0, 3'd0, 0, 1,  0, 32'h0,         0, 0, 0,  0, 0, 1};
        tbl[3] = '{1, 32'h0000_FFFF, 1, 1, 1, 3'd3, 0, 0,  1, 32'h0000_FFFF, 1, 0, 0,  0, 0, 1};
        tbl[4] = '{0, 32'h0,         0, 0, 0, 3'd0, 1, 0,  0, 32'h0,         0, 0, 0,  0, 0, 1};
        tbl[5] = '{1, 32'h1,         0, 0, 1, 3'd1, 0, 0,  1, 32'h1,         0, 0, 1,  0, 0, 1};
        tbl[6] = '{0, 32'h0,         0, 0, 0, 3'd0, 1, 1,  0, 32'h0,         0, 0, 0,  0, 1, 1};
        tbl[7] = '{0, 32'h0,         0, 0, 0, 3'd0, 0, 1,  0, 32'h0,         0, 0, 0,  0, 0, 1};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].iv; s = tbl[i].s; eq = tbl[i].eq; cary = tbl[i].cary;
            of = tbl[i].of; op = tbl[i].op; out_ready = tbl[i].ordy; sticky_clr = tbl[i].clr;
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
            chk($sformatf("vec%0d.s", i), 64'(out_s), 64'(tbl[i].e_s));
            chk($sformatf("vec%0d.flags", i), 64'({out_eq, out_cary, out_of}),
                64'({tbl[i].e_eq, tbl[i].e_cary, tbl[i].e_of}));
            chk($sformatf("vec%0d.sticky", i), 64'({sticky_cary, sticky_of}),
                64'({tbl[i].e_scary, tbl[i].e_sof}));
            chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(tbl[i].e_iready));
        end
        idle_inputs();

        // Fill to full with output stalled, then drain in order.
        do_reset();
        push_val(32'd1, 3'd2, 0, "full1");
        chk("full.ready_after1", 64'(in_ready), 64'd1);
        push_val(32'd2, 3'd2, 0, "full2");
        chk("full.ready_after2", 64'(in_ready), 64'd0);
        push_val(32'd3, 3'd2, 0, "full3");
        chk("full.head_held", 64'(out_s), 64'd1);
        in_valid = 1; s = 32'd3; out_ready = 1;
        tick("drain1");
        chk("drain.head2", 64'(out_s), 64'd2);
        tick("drain2");
        chk("drain.head3", 64'(out_s), 64'd3);
        in_valid = 0;
        tick("drain3");
        chk("drain.empty", 64'(out_valid), 64'd0);

        // Simultaneous push/pop with one entry resident, across pointer wrap.
        do_reset();
        push_val(32'd99, 3'd0, 0, "wrap_pre");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; s = 32'd100 + 32'(i); op = 3'd4; out_ready = 1;
            tick($sformatf("wrap%0d", i));
            chk($sformatf("wrap%0d.head", i), 64'(out_s), 64'd100 + 64'(i));
            chk($sformatf("wrap%0d.occ1", i), 64'({out_valid, in_ready}), 64'b11);
        end
        idle_inputs();

        // Asynchronous reset mid-cycle with entries buffered and a push pending.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; s = 32'(i); out_ready = 1;
            tick($sformatf("pre_rst%0d", i));
            in_valid = 0;
            tick($sformatf("pre_rst_pop%0d", i));
        end
        push_val(32'hAA, 3'd0, 0, "buf1");
        push_val(32'hBB, 3'd0, 0, "buf2");
        chk("rst.pop_count_before", 64'(pop_count), 64'(exp_pops()));
        in_valid = 1; s = 32'hCC;
        #1;
        rst = 1'b1;
        #1;
        chk("rst.async_valid", 64'(out_valid), 64'd0);
        chk("rst.async_ready", 64'(in_ready), 64'd1);
        chk("rst.async_count", 64'(pop_count), 64'd0);
        chk("rst.async_out_s", 64'(out_s), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_model("rst_hold");
        rst = 1'b0;
        push_val(32'd77, 3'd0, 0, "post_rst1");
        chk("post_rst.head", 64'(out_s), 64'd77);
        push_val(32'd78, 3'd0, 0, "post_rst2");
        chk("post_rst.full", 64'(in_ready), 64'd0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            s          = $urandom;
            eq         = 1'($urandom_range(0, 1));
            cary       = 1'($urandom_range(0, 1));
            of         = 1'($urandom_range(0, 1));
            op         = 3'($urandom_range(0, 7));
            out_ready  = ($urandom_range(0, 3) != 0);
            sticky_clr = ($urandom_range(0, 7) == 0);
            tick($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of result entries buffered (legal 2..8, power of two).
REQ-002 SHALL have parameter CNT_W, default 16, width of pop_count.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream ALU result valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept a result.
REQ-007 SHALL have port s  input  32  ALU result word.
REQ-008 SHALL have port eq, cary, of  input  1 each  ALU flags.
REQ-009 SHALL have port op  input  3  opcode tag: 000 ADD, 001 SUB, all others logic ops.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts head.
REQ-012 SHALL have ports out_s (32), out_eq, out_cary, out_of, out_op (3)  output  head entry fields.
REQ-013 SHALL have ports sticky_of, sticky_cary  output  1 each  accumulated flags.
REQ-014 SHALL have port sticky_clr  input  1  synchronous clear of sticky flags.
REQ-015 SHALL have port pop_count  output  CNT_W  number of results delivered.

Function
REQ-016 SHALL be a DEPTH-entry FIFO of {s, eq, cary, of, op}; push when in_valid && in_ready, pop when out_valid && out_ready.
REQ-017 SHALL drive in_ready = (occupancy != DEPTH), from registered state only; no combinational path from out_ready.
REQ-018 SHALL drive out_valid = (occupancy != 0); out_* fields from the head register, stable while out_valid && !out_ready.
REQ-019 SHALL, on push with op not 000/001, store cary=0 and of=0 regardless of input value (upstream logic slices float these flags); eq and s stored as given.
REQ-020 SHALL, on simultaneous push and pop, keep occupancy unchanged, the new entry queued behind remaining entries.
REQ-021 SHALL have latency of one cycle: entry pushed at edge N is visible on out_* after edge N when FIFO was empty.
REQ-022 SHALL wrap read/write pointers modulo DEPTH without losing or duplicating entries.
REQ-023 SHALL set sticky_of/sticky_cary on the edge that pops an entry with stored of/cary = 1.
REQ-024 SHALL clear both sticky flags when sticky_clr = 1; if a setting pop occurs in the same cycle, set wins.
REQ-025 SHALL drive out_s/out_eq/out_cary/out_of/out_op to 0 when out_valid = 0.

Reset
REQ-026 SHALL, on rst asserted, immediately clear occupancy and pointers: in_ready=1, out_valid=0, all out_* = 0, sticky flags=0, pop_count=0.
REQ-027 SHALL discard buffered entries and any in-flight push when rst asserts mid-operation; first push after deassertion lands in an empty FIFO.

Configuration
REQ-028 SHALL, with macro ALU_RESULT_STATS_EN defined, implement pop_count incrementing by 1 per pop, saturating at all-ones.
REQ-029 SHALL, without ALU_RESULT_STATS_EN, tie pop_count to 0 and implement no counter register; all other behaviour identical.

Verification
REQ-030 SHALL cover: push s=32'hF0F0_0000, op=000, cary=1, of=0 into empty, out_ready=1 -> next cycle out_valid=1, out_s=F0F0_0000, out_cary=1; following cycle sticky_cary=1.
REQ-031 SHALL cover: push s=32'h0000_FFFF, op=011 (OR), cary=1, of=1 -> out_cary=0, out_of=0, sticky flags unchanged after pop.
REQ-032 SHALL cover: DEPTH=2, out_ready=0, three consecutive pushes 1,2,3 -> in_ready=0 after second, third held; release out_ready -> outputs 1,2,3 in order.
REQ-033 SHALL cover: FIFO holding one entry, push and pop same cycle repeatedly for 10 cycles -> occupancy stays 1, data order preserved across pointer wrap.
REQ-034 SHALL cover: sticky_of=0, pop entry with of=1 while sticky_clr=1 -> sticky_of=1; next cycle sticky_clr=1 alone -> sticky_of=0.
REQ-035 SHALL cover: two entries buffered, pop_count=5 (stats build), assert rst asynchronously mid-cycle -> out_valid=0, in_ready=1, pop_count=0 before next clock edge.
